// File: rtl/iq_issue_if.sv
// Entry types and the issue-stage bus bundle (queue head window, issue lanes,
// writeback and flush).
package iq_issue_pkg;
    localparam int unsigned EXT_COUNT   = 4;
    localparam int unsigned ISSUE_WIDTH = 2;
    localparam int unsigned WB_COUNT    = 2;
    localparam int unsigned NREGS       = 32;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned TAG_W       = 8;

    typedef struct packed {
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic [REG_W-1:0] dest;
        logic             use_a;
        logic             use_b;
        logic             writes;
    } dec_inst_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        dec_inst_t        dec_inst;
        logic             stream;
    } iq_entry_t;
endpackage

interface iq_issue_if;
    import iq_issue_pkg::*;

    logic [EXT_COUNT-1:0]   ext_valid;
    iq_entry_t              in_elements [EXT_COUNT];
    logic [EXT_COUNT-1:0]   ext_consumed;
    logic                   ext_enable;
    logic [ISSUE_WIDTH-1:0] iss_valid;
    iq_entry_t              iss_inst [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] iss_ready;
    logic [WB_COUNT-1:0]    wb_valid;
    logic [REG_W-1:0]       wb_reg [WB_COUNT];
    logic                   flush;
    logic                   flush_stream;

    // master: the issue stage; slave: queue, execution units and writeback
    modport master (
        input  ext_valid, in_elements, iss_ready, wb_valid, wb_reg, flush, flush_stream,
        output ext_consumed, ext_enable, iss_valid, iss_inst
    );
    modport slave (
        output ext_valid, in_elements, iss_ready, wb_valid, wb_reg, flush, flush_stream,
        input  ext_consumed, ext_enable, iss_valid, iss_inst
    );
endinterface

// File: rtl/iq_issue.sv
// In-order issue stage: picks the longest hazard-free prefix of the queue head
// window that fits the free lanes, registers it per lane and tracks a scoreboard.
module iq_issue
    import iq_issue_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    iq_issue_if.master bus
);
    localparam int unsigned CNT_W = $clog2(EXT_COUNT + 1);
    localparam int unsigned IDX_W = $clog2(EXT_COUNT);

    logic [NREGS-1:0]       busy;
    logic [NREGS-1:0]       busy_stream;
    logic [NREGS-1:0]       busy_next;
    logic [NREGS-1:0]       busy_stream_next;
    logic [ISSUE_WIDTH-1:0] lane_free;
    logic [ISSUE_WIDTH-1:0] lane_load;
    logic [IDX_W-1:0]       lane_src [ISSUE_WIDTH];
    logic [EXT_COUNT-1:0]   consumed;
    logic [CNT_W-1:0]       free_cnt;
    logic [CNT_W-1:0]       sel_cnt;

    always_comb begin
        free_cnt = '0;
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            lane_free[k] = !bus.iss_valid[k] || bus.iss_ready[k];
            if (lane_free[k]) free_cnt = free_cnt + CNT_W'(1);
        end
    end

    // In-order prefix selection; pend tracks writers already picked this cycle.
    always_comb begin : select
        logic [NREGS-1:0] pend;
        logic             stop;
        logic             ok;
        dec_inst_t        d;
        consumed = '0;
        sel_cnt  = '0;
        pend     = '0;
        stop     = 1'b0;
        ok       = 1'b0;
        d        = '0;
        for (int i = 0; i < int'(EXT_COUNT); i++) begin
            d  = bus.in_elements[i].dec_inst;
            ok = bus.ext_valid[i] && reset_n;
            if (d.use_a && (busy[d.src_a] || pend[d.src_a])) ok = 1'b0;
            if (d.use_b && (busy[d.src_b] || pend[d.src_b])) ok = 1'b0;
            if (d.writes && (busy[d.dest] || pend[d.dest])) ok = 1'b0;
            if (sel_cnt >= free_cnt) ok = 1'b0;
            if (bus.flush && (bus.in_elements[i].stream == bus.flush_stream)) ok = 1'b0;
            if (!ok) stop = 1'b1;
            if (!stop) begin
                consumed[i] = 1'b1;
                sel_cnt     = sel_cnt + CNT_W'(1);
                if (d.writes && (d.dest != '0)) pend[d.dest] = 1'b1;
            end
        end
    end

    assign bus.ext_consumed = consumed;
    assign bus.ext_enable   = |consumed;

    // Oldest selected slot goes to the lowest free lane.
    always_comb begin : lane_map
        logic [CNT_W-1:0] j;
        j = '0;
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            lane_load[k] = 1'b0;
            lane_src[k]  = '0;
            if (lane_free[k] && (j < sel_cnt)) begin
                lane_load[k] = 1'b1;
                lane_src[k]  = IDX_W'(j);
                j            = j + CNT_W'(1);
            end
        end
    end

    // Issued writers override same-edge writeback and flush clears.
    always_comb begin
        busy_next        = busy;
        busy_stream_next = busy_stream;
        for (int w = 0; w < int'(WB_COUNT); w++) begin
            if (bus.wb_valid[w]) busy_next[bus.wb_reg[w]] = 1'b0;
        end
        if (bus.flush) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                if (busy_stream[r] == bus.flush_stream) busy_next[r] = 1'b0;
            end
        end
        for (int i = 0; i < int'(EXT_COUNT); i++) begin
            if (consumed[i] && bus.in_elements[i].dec_inst.writes) begin
                busy_next[bus.in_elements[i].dec_inst.dest]        = 1'b1;
                busy_stream_next[bus.in_elements[i].dec_inst.dest] = bus.in_elements[i].stream;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= '0;
            busy_stream <= '0;
        end else begin
            busy        <= busy_next;
            busy_stream <= busy_stream_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.iss_valid <= '0;
            for (int k = 0; k < int'(ISSUE_WIDTH); k++) bus.iss_inst[k] <= '0;
        end else begin
            for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
                if (lane_load[k]) begin
                    bus.iss_valid[k] <= 1'b1;
                    bus.iss_inst[k]  <= bus.in_elements[lane_src[k]];
                end else if (lane_free[k]) begin
                    bus.iss_valid[k] <= 1'b0;
                end else if (bus.flush && (bus.iss_inst[k].stream == bus.flush_stream)) begin
                    bus.iss_valid[k] <= 1'b0;
                end
            end
        end
    end
endmodule
